pipelined_ram: RTL

PIPELINED_RAM -- requirements
Module: pipelined_ram

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_rd_pipe.sv | 41 ++++
 rtl/pipelined_ram.sv | 108 ++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the pipelined RAM
package ram_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - RD_LAT-deep valid/data shift register for read results
module ram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [RD_LAT-1:0] valid_q;
    logic [DATA_W-1:0] data_q [RD_LAT];

    // Shift valid every cycle; data stages only load behind a valid so the last stage holds its value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign valid_o = valid_q[RD_LAT-1];
    assign data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/pipelined_ram.sv
// rtl/pipelined_ram.sv - single-port byte-enabled RAM with zero-fill init and pipelined reads
module pipelined_ram
    import ram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Req,
    input  logic                WE,
    input  logic [ADDR_W-1:0]   Address,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [DATA_W/8-1:0] ByteEn,
    output logic                Ready,
    output logic [DATA_W-1:0]   ReadData,
    output logic                ReadValid,
    output logic                InitDone
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
        $error("pipelined_ram: RD_LAT must be within 1..4");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("pipelined_ram: DATA_W must be a multiple of 8");
    end

    ram_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_done_q, init_done_d;
    logic                fill_we;
    logic                accept;
    logic [DATA_W-1:0]   mem [DEPTH];

    // FSM state, fill counter and done flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Next state: walk the counter once over the array, holding at the top address instead of wrapping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        fill_we     = 1'b0;
        case (state_q)
            INIT: begin
                if (INIT_ZERO != 0) begin
                    fill_we = 1'b1;
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_d     = RUN;
                        init_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN:     ;
            default: state_d = INIT;
        endcase
    end

    assign Ready    = (state_q == RUN);
    assign accept   = Req && Ready;
    assign InitDone = init_done_q;

    // Array write port: zero-fill during INIT (never while reset is held), byte-masked writes in RUN.
    always_ff @(posedge Clk) begin
        if (fill_we && Reset_n) begin
            mem[cnt_q] <= '0;
        end else if (accept && WE) begin
            for (int b = 0; b < NB; b++) begin
                if (ByteEn[b]) begin
                    mem[Address][b*8 +: 8] <= WriteData[b*8 +: 8];
                end
            end
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .valid_i (accept && !WE),
        .data_i  (mem[Address]),
        .valid_o (ReadValid),
        .data_o  (ReadData)
    );

endmodule
